bufin_gather: RTL and testbench

//  Parametrised complex-sample input buffer for the radix-R FFT butterflies.
//  - Accepts one complex sample per cycle on a valid/ready stream.
//  - Gathers RADIX consecutive samples into one group and presents the group
//    in parallel to the butterfly, through a registered output with valid/ready.
//  - Ping-pong (two-bank) storage: one bank fills while the other is held,
//    so a full sample rate is sustained. Generalises the fixed 3-lane register stage.

---
 rtl/bufin_gather.sv | 97 +++++++++
 tb/tb_bufin_gather.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bufin_gather.sv
// Ping-pong complex-sample input buffer: gathers RADIX consecutive samples
// into one group and presents it in parallel to the radix-R butterfly.
module bufin_gather #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RADIX = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sync,
    input  logic [WIDTH-1:0]       in_re,
    input  logic [WIDTH-1:0]       in_img,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RADIX*WIDTH-1:0] out_re,
    output logic [RADIX*WIDTH-1:0] out_img,
    output logic                   drop_err
);

    localparam int unsigned IDX_W = (RADIX > 1) ? $clog2(RADIX) : 1;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(RADIX - 1);

    logic [WIDTH-1:0] r_bank_re [2][RADIX];
    logic [WIDTH-1:0] r_bank_im [2][RADIX];
    logic [1:0]       r_full;
    logic             r_wb;
    logic             r_rb;
    logic [IDX_W-1:0] r_idx;
    logic             r_drop;

    logic             w_in_fire;
    logic             w_out_fire;
    logic [IDX_W-1:0] w_lane;
    logic             w_last;
    logic [1:0]       w_full_nxt;

    // Ready looks only at the write bank's pre-edge flag, so a bank being
    // drained this cycle can never be written in the same cycle.
    assign in_ready   = ~r_full[r_wb] & ~rst;
    assign out_valid  = r_full[r_rb];
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_lane     = in_sync ? '0 : r_idx;
    assign w_last     = (w_lane == LAST_LANE);
    assign drop_err   = r_drop;

    // Fill and drain always touch different banks, so both can apply at once.
    always_comb begin
        w_full_nxt = r_full;
        if (w_out_fire) begin
            w_full_nxt[r_rb] = 1'b0;
        end
        if (w_in_fire && w_last) begin
            w_full_nxt[r_wb] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= '0;
            r_wb   <= 1'b0;
            r_rb   <= 1'b0;
            r_idx  <= '0;
            r_drop <= 1'b0;
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned k = 0; k < RADIX; k++) begin
                    r_bank_re[b][k] <= '0;
                    r_bank_im[b][k] <= '0;
                end
            end
        end else begin
            r_full <= w_full_nxt;
            r_drop <= w_in_fire & in_sync & (r_idx != '0);
            if (w_out_fire) begin
                r_rb <= ~r_rb;
            end
            if (w_in_fire) begin
                r_bank_re[r_wb][w_lane] <= in_re;
                r_bank_im[r_wb][w_lane] <= in_img;
                if (w_last) begin
                    r_wb  <= ~r_wb;
                    r_idx <= '0;
                end else begin
                    r_idx <= w_lane + IDX_W'(1);
                end
            end
        end
    end

    // Lane k of the read bank drives slice k; lane 0 is the first sample in.
    for (genvar k = 0; k < RADIX; k++) begin : g_lane
        assign out_re[k*WIDTH +: WIDTH]  = r_bank_re[r_rb][k];
        assign out_img[k*WIDTH +: WIDTH] = r_bank_im[r_rb][k];
    end

endmodule

// File: tb/tb_bufin_gather.sv
// Self-checking bench for bufin_gather (RADIX=3, WIDTH=32): a negedge monitor
// models the gather and scoreboards every output group against it.
module tb_bufin_gather;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned RADIX = 3;
    localparam int unsigned GW    = 2 * RADIX * WIDTH;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sync;
    logic [WIDTH-1:0]       in_re;
    logic [WIDTH-1:0]       in_img;
    logic                   out_valid;
    logic                   out_ready;
    logic [RADIX*WIDTH-1:0] out_re;
    logic [RADIX*WIDTH-1:0] out_img;
    logic                   drop_err;

    int n_chk = 0;
    int n_err = 0;

    logic [GW-1:0]    sb_q [$];
    logic [WIDTH-1:0] m_re [RADIX];
    logic [WIDTH-1:0] m_im [RADIX];
    int               m_idx = 0;
    int               n_grp = 0;
    int               drop_exp = 0;
    int               drop_seen = 0;
    int               stalls = 0;
    bit               stall_watch = 0;
    bit               done5 = 0;

    bufin_gather #(.WIDTH(WIDTH), .RADIX(RADIX)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sync  (in_sync),
        .in_re    (in_re),
        .in_img   (in_img),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_re   (out_re),
        .out_img  (out_img),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [GW-1:0] got, input logic [GW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Holds the sample on the bus until it is accepted (bounded), then releases.
    task automatic send(input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im, input logic sync);
        bit ok;
        int n;
        in_valid = 1'b1;
        in_sync  = sync;
        in_re    = re;
        in_img   = im;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("send_timeout", GW'(0), GW'(1));
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    // Reference model: predicts what the coming clock edge does.
    always @(negedge clk) begin
        logic [GW-1:0] exp_g;
        int            lane;
        if (rst) begin
            sb_q.delete();
            m_idx = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", GW'(1), GW'(0));
                end else begin
                    exp_g = sb_q.pop_front();
                    chk("group", {out_re, out_img}, exp_g);
                    n_grp++;
                end
            end
            if (in_valid && in_ready) begin
                lane = in_sync ? 0 : m_idx;
                if (in_sync && m_idx != 0) drop_exp++;
                m_re[lane] = in_re;
                m_im[lane] = in_img;
                if (lane == RADIX - 1) begin
                    sb_q.push_back({m_re[2], m_re[1], m_re[0], m_im[2], m_im[1], m_im[0]});
                    m_idx = 0;
                end else begin
                    m_idx = lane + 1;
                end
            end else if (in_valid && stall_watch) begin
                stalls++;
            end
            if (drop_err) drop_seen++;
        end
    end

    initial begin
        int g0;
        int d0;
        logic [RADIX*WIDTH-1:0] hold;

        rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0; in_re = '0; in_img = '0; out_ready = 1'b0;

        // 1) reset
        @(negedge clk);
        chk("rst_in_ready", GW'(in_ready), GW'(0));
        chk("rst_out_valid", GW'(out_valid), GW'(0));
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready2", GW'(in_ready), GW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", GW'(in_ready), GW'(1));
        chk("post_rst_out_valid", GW'(out_valid), GW'(0));
        chk("post_rst_out_re", GW'(out_re), GW'(0));
        @(posedge clk); #1;

        // 2) single group, latency and one-cycle presentation
        out_ready = 1'b1;
        send(32'd1, 32'(-1), 1'b0);
        send(32'd2, 32'(-2), 1'b0);
        send(32'd3, 32'(-3), 1'b0);
        @(negedge clk);
        chk("lat_out_valid", GW'(out_valid), GW'(1));
        chk("lat_out_re", GW'(out_re), GW'({32'd3, 32'd2, 32'd1}));
        chk("lat_out_img", GW'(out_img), GW'({32'(-3), 32'(-2), 32'(-1)}));
        @(negedge clk);
        chk("one_cycle_valid", GW'(out_valid), GW'(0));
        @(posedge clk); #1;

        // 3) both banks full, backpressure, stable output
        out_ready = 1'b0;
        g0 = n_grp;
        for (int i = 0; i < 6; i++) send(WIDTH'(10 + i), WIDTH'(20 + i), 1'b0);
        @(negedge clk);
        chk("full_in_ready", GW'(in_ready), GW'(0));
        hold = out_re;
        in_valid = 1'b1; in_re = 32'd16; in_img = 32'd26;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_no_accept", GW'(in_ready), GW'(0));
            chk("hold_out_valid", GW'(out_valid), GW'(1));
            chk("hold_out_re", GW'(out_re), GW'(hold));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_valid", GW'(out_valid), GW'(1));
        chk("drain_first", GW'(out_re), GW'({32'd12, 32'd11, 32'd10}));
        @(negedge clk);
        chk("ready_after_fire", GW'(in_ready), GW'(1));
        repeat (4) @(negedge clk);
        chk("full_groups", GW'(n_grp - g0), GW'(2));
        @(posedge clk); #1;

        // 4) in_sync discards a partial group
        g0 = n_grp;
        d0 = drop_seen;
        send(32'd5, 32'd0, 1'b0);
        send(32'd6, 32'd0, 1'b0);
        send(32'd7, 32'd0, 1'b1);
        send(32'd8, 32'd0, 1'b0);
        send(32'd9, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("drop_pulses", GW'(drop_seen - d0), GW'(1));
        chk("drop_groups", GW'(n_grp - g0), GW'(1));
        @(posedge clk); #1;

        // 5) streaming with out_ready toggling
        g0 = n_grp;
        stalls = 0;
        stall_watch = 1'b1;
        done5 = 1'b0;
        fork
            begin
                for (int i = 0; i < 3 * 30; i++)
                    send(WIDTH'(32'h1000 + i), WIDTH'($urandom), 1'b0);
                done5 = 1'b1;
            end
            begin
                while (!done5) begin
                    @(posedge clk); #1;
                    out_ready = ~out_ready;
                end
            end
        join
        stall_watch = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("stream_stalls", GW'(stalls), GW'(0));
        chk("stream_groups", GW'(n_grp - g0), GW'(30));
        @(posedge clk); #1;

        // 6) reset with one full bank and a partial group
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(WIDTH'(40 + i), WIDTH'(60 + i), 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", GW'(out_valid), GW'(0));
        chk("mid_rst_in_ready", GW'(in_ready), GW'(1));
        chk("mid_rst_out_re", GW'(out_re), GW'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        g0 = n_grp;
        send(32'd50, 32'd70, 1'b0);
        send(32'd51, 32'd71, 1'b0);
        send(32'd52, 32'd72, 1'b0);
        @(negedge clk);
        chk("rst_group_re", GW'(out_re), GW'({32'd52, 32'd51, 32'd50}));
        repeat (3) @(negedge clk);
        chk("rst_groups", GW'(n_grp - g0), GW'(1));

        chk("sb_leftover", GW'(sb_q.size()), GW'(0));
        chk("drop_total", GW'(drop_seen), GW'(drop_exp));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
